stage_chain: RTL

- Sequential, parametrised successor to the single-stage pass/bonus evaluator.
- Runs a chain of NUM_STAGES stages, accepting one stage record (work, hard, luck) per handshake.
- Carries pass and bonus from each stage into the next, and adds a burnout rule for excessive effort.
- Sits between the stimulus/record source and the result collector; reports final pass, final bonus and number of stages cleared.

---
 rtl/stage_chain_pkg.sv | 19 +
 rtl/stage_chain_eval.sv | 39 +++
 rtl/stage_chain.sv | 133 +++++++++++++
 3 files changed

// File: rtl/stage_chain_pkg.sv
// Shared types, default constants and helpers for the multi-stage pass/bonus chain.
package stage_chain_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_MAX_SCORE   = 100;
  localparam int DEF_BURNOUT_TH  = 95;
  localparam int DEF_BONUS_SHIFT = 2;
  localparam int DEF_COUNT_SHIFT = 5;

  // Internal arithmetic width: covers work + two shifted bonus terms for any practical SCORE_W.
  localparam int CALC_W = 16;

  function automatic logic [CALC_W-1:0] sat_min(input logic [CALC_W-1:0] value,
                                                input logic [CALC_W-1:0] ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/stage_chain_eval.sv
// Combinational evaluation of one stage record: score, burnout, pass and carried bonus.
module stage_eval
  import stage_chain_pkg::*;
#(
  parameter int SCORE_W     = 7,
  parameter int MAX_SCORE   = DEF_MAX_SCORE,
  parameter int BONUS_W     = 2,
  parameter int BONUS_SHIFT = DEF_BONUS_SHIFT,
  parameter int COUNT_SHIFT = DEF_COUNT_SHIFT,
  parameter int BURNOUT_TH  = DEF_BURNOUT_TH
) (
  input  logic [SCORE_W-1:0] work,
  input  logic [SCORE_W-1:0] hard,
  input  logic [BONUS_W-1:0] luck,
  input  logic [BONUS_W-1:0] bonus_prev,
  input  logic               over_prev,
  output logic               stage_pass,
  output logic [BONUS_W-1:0] new_bonus,
  output logic               over
);

  logic [CALC_W-1:0] total;
  logic [CALC_W-1:0] score;
  logic [CALC_W-1:0] bonus_sat;
  logic              burnout;

  always_comb begin
    total     = CALC_W'(work) + (CALC_W'(bonus_prev) << BONUS_SHIFT)
              + (CALC_W'(luck) << BONUS_SHIFT);
    score     = sat_min(total, CALC_W'(MAX_SCORE));
    bonus_sat = sat_min(total >> COUNT_SHIFT, CALC_W'((2 ** BONUS_W) - 1));
    over      = CALC_W'(work) > CALC_W'(BURNOUT_TH);
    burnout   = over & over_prev;
    stage_pass = (score > CALC_W'(hard)) & ~burnout;
  end

  assign new_bonus = BONUS_W'(bonus_sat);

endmodule

// File: rtl/stage_chain.sv
// Sequencer that feeds NUM_STAGES handshaked stage records through stage_eval,
// carrying bonus and over-effort forward and reporting the final outcome.
module stage_chain
  import stage_chain_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int SCORE_W     = 7,
  parameter int MAX_SCORE   = DEF_MAX_SCORE,
  parameter int BONUS_W     = 2,
  parameter int BONUS_SHIFT = DEF_BONUS_SHIFT,
  parameter int COUNT_SHIFT = DEF_COUNT_SHIFT,
  parameter int BURNOUT_TH  = DEF_BURNOUT_TH,
  localparam int CNT_W      = $clog2(NUM_STAGES + 1),
  localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stg_valid,
  output logic               stg_ready,
  input  logic [SCORE_W-1:0] work,
  input  logic [SCORE_W-1:0] hard,
  input  logic [BONUS_W-1:0] luck,
  output logic               busy,
  output logic               done,
  output logic               pass_out,
  output logic [BONUS_W-1:0] bonus_out,
  output logic [CNT_W-1:0]   stages_cleared,
  output logic [IDX_W-1:0]   stage_idx
);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx_next;
  logic [CNT_W-1:0]   cleared_next;
  logic [BONUS_W-1:0] bonus_prev, bonus_prev_next;
  logic               over_prev, over_prev_next;
  logic               pass_next;
  logic [BONUS_W-1:0] bonus_out_next;

  logic               stage_pass;
  logic [BONUS_W-1:0] new_bonus;
  logic               over;

  stage_eval #(
    .SCORE_W    (SCORE_W),
    .MAX_SCORE  (MAX_SCORE),
    .BONUS_W    (BONUS_W),
    .BONUS_SHIFT(BONUS_SHIFT),
    .COUNT_SHIFT(COUNT_SHIFT),
    .BURNOUT_TH (BURNOUT_TH)
  ) u_eval (
    .work      (work),
    .hard      (hard),
    .luck      (luck),
    .bonus_prev(bonus_prev),
    .over_prev (over_prev),
    .stage_pass(stage_pass),
    .new_bonus (new_bonus),
    .over      (over)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      stage_idx      <= '0;
      stages_cleared <= '0;
      bonus_prev     <= '0;
      over_prev      <= 1'b0;
      pass_out       <= 1'b0;
      bonus_out      <= '0;
    end else begin
      state          <= state_next;
      stage_idx      <= idx_next;
      stages_cleared <= cleared_next;
      bonus_prev     <= bonus_prev_next;
      over_prev      <= over_prev_next;
      pass_out       <= pass_next;
      bonus_out      <= bonus_out_next;
    end
  end

  always_comb begin
    state_next      = state;
    idx_next        = stage_idx;
    cleared_next    = stages_cleared;
    bonus_prev_next = bonus_prev;
    over_prev_next  = over_prev;
    pass_next       = pass_out;
    bonus_out_next  = bonus_out;

    case (state)
      IDLE: begin
        // Clearing carried state here guarantees stage 0 sees zero bonus and no prior over-effort.
        if (start) begin
          state_next      = RUN;
          idx_next        = '0;
          cleared_next    = '0;
          bonus_prev_next = '0;
          over_prev_next  = 1'b0;
          pass_next       = 1'b0;
          bonus_out_next  = '0;
        end
      end
      RUN: begin
        if (stg_valid) begin
          if (stage_pass) begin
            bonus_prev_next = new_bonus;
            over_prev_next  = over;
            cleared_next    = stages_cleared + CNT_W'(1);
            if (stage_idx == IDX_W'(NUM_STAGES - 1)) begin
              pass_next      = 1'b1;
              bonus_out_next = new_bonus;
              state_next     = DONE;
            end else begin
              idx_next = stage_idx + IDX_W'(1);
            end
          end else begin
            pass_next      = 1'b0;
            bonus_out_next = '0;
            state_next     = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign stg_ready = (state == RUN);
  assign done      = (state == DONE);

endmodule
